// File: rtl/cpc_pkg.sv
// Purpose: shared constants and types for the CPC host boot/ROM loading path.
// Latency: n/a (package only).
// Backpressure: n/a. Provides header command codes, header field layout and loader state type.
package cpc_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_DONE = 8'hFF;

    // Header word layout: [31:24] cmd, [23:16] slot, [15:0] byte count
    localparam int HDR_CMD_LSB  = 24;
    localparam int HDR_SLOT_LSB = 16;
    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_CNT_W    = 16;

    typedef struct packed {
        logic [7:0]           cmd;
        logic [7:0]           slot;
        logic [HDR_CNT_W-1:0] count;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ACK,
        ST_WAIT_WORD,
        ST_UNPACK,
        ST_WORD_ACK,
        ST_DONE
    } ldr_state_e;

endpackage

// File: rtl/cpc_req_ack_slave.sv
// Purpose: 4-phase req/ack slave; captures a word, pulses word_valid_o, acks once word_done_i is seen.
// Latency: capture on first clk with req_i=1 (and accept_i); ack_o rises the cycle after word_done_i.
// Backpressure: ack_o is withheld until the consumer signals word_done_i; ack_o drops once req_i is seen low.
// Ports: clk/reset (async, active-high); accept_i consumer ready; req_i/data_i/ack_o host side;
//        word_valid_o one-cycle capture pulse, word_o captured word, word_done_i consumer finished.
module cpc_req_ack_slave #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept_i,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o,
    input  logic              word_done_i
);

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_BUSY,
        HS_ACK
    } hs_state_e;

    hs_state_e         state_q, state_d;
    logic [DATA_W-1:0] word_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HS_IDLE: if (req_i && accept_i) state_d = HS_BUSY;
            HS_BUSY: if (word_done_i)       state_d = HS_ACK;
            HS_ACK:  if (!req_i)            state_d = HS_IDLE;
            default:                        state_d = HS_IDLE;
        endcase
    end

    // Outputs: ack decoded from the state register, so it is glitch-free
    always_comb begin
        ack_o        = (state_q == HS_ACK);
        word_valid_o = (state_q == HS_IDLE) && req_i && accept_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
        end else if (word_valid_o) begin
            word_q <= data_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/cpc_rom_loader.sv
// Purpose: host-to-SRAM ROM loader; header words pick a ROM slot, payload bytes are written to SRAM.
// Latency: header ack 1 cycle after capture; payload ack 1 cycle after the word's last granted byte write.
// Backpressure: payload ack waits for all bytes of the word; mem_gnt may drop any cycle, stalling with addr/data held.
// Ports: clk/reset (async, active-high); host_bootdata/_req/_ack host 4-phase link;
//        host_rom_initialised, slot_valid, load_error, busy status; mem_req/mem_gnt arbiter;
//        sram_addr/sram_dout/sram_we byte write port (sram_we = mem_req & mem_gnt).
module cpc_rom_loader
    import cpc_pkg::*;
#(
    parameter int                ADDR_W    = 21,
    parameter int                NUM_SLOTS = 8,
    parameter int                SLOT_LOG2 = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 21'h100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          host_bootdata,
    input  logic                 host_bootdata_req,
    output logic                 host_bootdata_ack,
    output logic                 host_rom_initialised,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 load_error,
    output logic                 busy,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [7:0]           sram_dout,
    output logic                 sram_we
);

    localparam int SLOT_BYTES = 1 << SLOT_LOG2;

    ldr_state_e           state_q, state_d;
    logic                 word_valid;
    logic                 word_done;
    logic                 accept;
    logic [31:0]          word_q;
    hdr_t                 hdr;

    logic [7:0]           slot_q;
    logic [15:0]          rem_q;
    logic [1:0]           byte_idx_q;
    logic [SLOT_LOG2:0]   offset_q;
    logic                 discard_q;
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic                 init_q;
    logic                 err_q;
    logic                 mem_req_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           dout_q;

    logic                 hdr_is_load;
    logic                 hdr_bad;
    logic [NUM_SLOTS-1:0] hdr_mask;
    logic [NUM_SLOTS-1:0] slot_mask;
    logic [ADDR_W-1:0]    slot_base;
    logic                 last_byte;
    logic [1:0]           next_idx;
    logic [7:0]           next_byte;
    logic                 ack_release;

    cpc_req_ack_slave #(.DATA_W(32)) u_hs (
        .clk          (clk),
        .reset        (reset),
        .accept_i     (accept),
        .req_i        (host_bootdata_req),
        .data_i       (host_bootdata),
        .ack_o        (host_bootdata_ack),
        .word_valid_o (word_valid),
        .word_o       (word_q),
        .word_done_i  (word_done)
    );

    assign hdr         = hdr_t'(word_q);
    assign hdr_is_load = (hdr.cmd == CMD_LOAD);
    assign hdr_bad     = (int'(hdr.slot) >= NUM_SLOTS) || (int'(hdr.count) > SLOT_BYTES);
    // Out-of-range slots shift the bit out entirely; only used for in-range slots anyway
    assign hdr_mask    = NUM_SLOTS'(1) << hdr.slot;
    assign slot_mask   = NUM_SLOTS'(1) << slot_q;
    assign slot_base   = BASE_ADDR + (ADDR_W'(slot_q) << SLOT_LOG2);
    // Partial last word: stop as soon as the remaining count hits its final byte
    assign last_byte   = (byte_idx_q == 2'd3) || (rem_q == 16'd1);
    assign next_idx    = byte_idx_q + 2'd1;
    assign next_byte   = word_q[{next_idx, 3'b000} +: 8];
    // Host has seen our ack and dropped req: the handshake slave releases ack this edge
    assign ack_release = host_bootdata_ack && !host_bootdata_req;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (word_valid) state_d = ST_HDR_ACK;
            end
            ST_HDR_ACK: begin
                if (hdr_is_load && (hdr.count != 16'd0)) begin
                    state_d = ST_WAIT_WORD;
                end else if (init_q || (hdr.cmd == CMD_DONE)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_WORD: begin
                if (word_valid) state_d = discard_q ? ST_WORD_ACK : ST_UNPACK;
            end
            ST_UNPACK: begin
                if (sram_we && last_byte) state_d = ST_WORD_ACK;
            end
            ST_WORD_ACK: begin
                if (ack_release) begin
                    if (rem_q != 16'd0) begin
                        state_d = ST_WAIT_WORD;
                    end else begin
                        state_d = init_q ? ST_DONE : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        accept    = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_WAIT_WORD);
        // Discarded payload words are released on their first WORD_ACK cycle (ack still low)
        word_done = (state_q == ST_HDR_ACK)
                 || ((state_q == ST_UNPACK) && sram_we && last_byte)
                 || ((state_q == ST_WORD_ACK) && !host_bootdata_ack);
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= '0;
            rem_q        <= '0;
            byte_idx_q   <= '0;
            offset_q     <= '0;
            discard_q    <= 1'b0;
            slot_valid_q <= '0;
            init_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
        end else begin
            case (state_q)
                ST_HDR_ACK: begin
                    if (hdr_is_load) begin
                        rem_q    <= hdr.count;
                        offset_q <= '0;
                        slot_q   <= hdr.slot;
                        if (hdr_bad) begin
                            err_q     <= 1'b1;
                            discard_q <= 1'b1;
                        end else begin
                            discard_q <= 1'b0;
                            // Reloading invalidates the slot; an empty image is complete at once
                            slot_valid_q <= (slot_valid_q & ~hdr_mask)
                                          | ((hdr.count == 16'd0) ? hdr_mask : '0);
                        end
                    end else if (hdr.cmd == CMD_DONE) begin
                        init_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ST_WAIT_WORD: begin
                    if (word_valid) begin
                        if (discard_q) begin
                            rem_q <= (rem_q > 16'd4) ? (rem_q - 16'd4) : 16'd0;
                        end else begin
                            // Word is captured this same edge, so byte 0 comes from the live bus
                            mem_req_q  <= 1'b1;
                            byte_idx_q <= 2'd0;
                            addr_q     <= slot_base + ADDR_W'(offset_q);
                            dout_q     <= host_bootdata[7:0];
                        end
                    end
                end
                ST_UNPACK: begin
                    if (sram_we) begin
                        rem_q      <= rem_q - 16'd1;
                        offset_q   <= offset_q + 1'b1;
                        byte_idx_q <= next_idx;
                        if (last_byte) begin
                            mem_req_q <= 1'b0;
                        end else begin
                            addr_q <= slot_base + ADDR_W'(offset_q + 1'b1);
                            dout_q <= next_byte;
                        end
                    end
                end
                ST_WORD_ACK: begin
                    if (ack_release && (rem_q == 16'd0) && !discard_q) begin
                        slot_valid_q <= slot_valid_q | slot_mask;
                    end
                end
                default: ;
            endcase
        end
    end

    assign host_rom_initialised = init_q;
    assign slot_valid           = slot_valid_q;
    assign load_error           = err_q;
    assign mem_req              = mem_req_q;
    assign sram_addr            = addr_q;
    assign sram_dout            = dout_q;
    assign sram_we              = mem_req_q & mem_gnt;

endmodule
